// File: rtl/parallel_serial_par.sv
// Parallel-to-serial converter: one-word holding register feeding a per-lane
// shift word, with an idle-comma preamble after reset and idle fill when starved.
module parallel_serial_par #(
   parameter int               WIDTH      = 8,
   parameter int               LANES      = 1,
   parameter logic [WIDTH-1:0] IDLE_WORD  = 8'hBC,
   parameter int               SYNC_WORDS = 2,
   parameter bit               MSB_FIRST  = 1'b1
) (
   input  logic                   clk_4f,
   input  logic                   reset,
   input  logic [LANES*WIDTH-1:0] data_in,
   input  logic                   valid_in,
   output logic                   ready_out,
   output logic [LANES-1:0]       data_out,
   output logic                   word_start,
   output logic                   is_data,
   output logic [LANES*WIDTH-1:0] data2send
);

   localparam int               CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int               IW        = $clog2(SYNC_WORDS + 1);
   localparam logic [CW-1:0]    CNT_LAST  = CW'(WIDTH - 1);
   localparam logic [IW-1:0]    SYNC_LAST = IW'(SYNC_WORDS - 1);

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_INIT  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t                 state_r, state_s;
   logic [CW-1:0]          cnt_r, cnt_s;
   logic [LANES*WIDTH-1:0] hold_r, hold_s;
   logic                   hold_full_r, hold_full_s;
   logic [LANES*WIDTH-1:0] shift_r, shift_s;
   logic                   is_data_r, is_data_s;
   logic [IW-1:0]          init_cnt_r, init_cnt_s;

   logic                   running_s;
   logic                   last_bit_s;
   logic                   load_s;
   logic                   transfer_s;
   int                     bit_sel_s;

   function automatic logic [LANES*WIDTH-1:0] idle_lanes();
      logic [LANES*WIDTH-1:0] w;
      w = '0;
      for (int k = 0; k < LANES; k++) begin
         w[k*WIDTH +: WIDTH] = IDLE_WORD;
      end
      return w;
   endfunction

   // Output decode and handshake, all derived from registered state only.
   always_comb begin
      running_s  = (state_r != ST_RESET);
      last_bit_s = (cnt_r == CNT_LAST);
      load_s     = running_s && last_bit_s;
      word_start = running_s && (cnt_r == '0);
      ready_out  = (state_r == ST_RUN) && (!hold_full_r || last_bit_s);
      transfer_s = valid_in && ready_out;
      is_data    = is_data_r;
      data2send  = shift_r;
      bit_sel_s  = MSB_FIRST ? (WIDTH - 1 - int'(cnt_r)) : int'(cnt_r);
      data_out   = '0;
      for (int k = 0; k < LANES; k++) begin
         data_out[k] = shift_r[k*WIDTH + bit_sel_s];
      end
   end

   // Next-state logic: FSM, bit counter, holding register and shift word.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      hold_s      = hold_r;
      hold_full_s = hold_full_r;
      shift_s     = shift_r;
      is_data_s   = is_data_r;
      init_cnt_s  = init_cnt_r;
      case (state_r)
         ST_RESET: begin
            // The release edge is itself a load edge for the first idle word.
            state_s    = ST_INIT;
            cnt_s      = '0;
            shift_s    = idle_lanes();
            is_data_s  = 1'b0;
            init_cnt_s = IW'(1);
         end
         ST_INIT, ST_RUN: begin
            cnt_s = last_bit_s ? '0 : cnt_r + CW'(1);
            if (load_s) begin
               if (hold_full_r) begin
                  shift_s   = hold_r;
                  is_data_s = 1'b1;
               end else begin
                  shift_s   = idle_lanes();
                  is_data_s = 1'b0;
               end
            end else begin
               shift_s   = shift_r;
               is_data_s = is_data_r;
            end
            // A capture on the load edge refills the slot just vacated.
            if (transfer_s) begin
               hold_s      = data_in;
               hold_full_s = 1'b1;
            end else if (load_s && hold_full_r) begin
               hold_full_s = 1'b0;
            end else begin
               hold_full_s = hold_full_r;
            end
            if ((state_r == ST_INIT) && load_s) begin
               if (init_cnt_r >= SYNC_LAST) begin
                  state_s = ST_RUN;
               end else begin
                  init_cnt_s = init_cnt_r + IW'(1);
               end
            end else begin
               init_cnt_s = init_cnt_r;
            end
         end
         default: begin
            state_s = ST_RESET;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_4f) begin
      if (!reset) begin
         state_r     <= ST_RESET;
         cnt_r       <= CNT_LAST;
         hold_r      <= '0;
         hold_full_r <= 1'b0;
         shift_r     <= '0;
         is_data_r   <= 1'b0;
         init_cnt_r  <= '0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         hold_r      <= hold_s;
         hold_full_r <= hold_full_s;
         shift_r     <= shift_s;
         is_data_r   <= is_data_s;
         init_cnt_r  <= init_cnt_s;
      end
   end

endmodule

// File: tb/tb_parallel_serial_par.sv
// Directed bench for parallel_serial_par: table-driven cycle vectors on the
// default configuration plus LSB-first and two-lane variants.
module tb_parallel_serial_par;

   logic clk_4f = 1'b0;
   always #5 clk_4f = ~clk_4f;

   logic       reset;
   logic [7:0] din_a, d2s_a;
   logic       val_a, rdy_a, ws_a, isd_a;
   logic [0:0] dout_a;
   logic [7:0] din_l, d2s_l;
   logic       val_l, rdy_l, ws_l, isd_l;
   logic [0:0] dout_l;
   logic [7:0] din_d, d2s_d;
   logic       val_d, rdy_d, ws_d, isd_d;
   logic [1:0] dout_d;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       valid;
      logic [7:0] din;
      logic       rdy;
      logic       isd;
      logic [7:0] word;
   } vec_t;
   vec_t tbl[48];

   parallel_serial_par u_main (
      .clk_4f(clk_4f), .reset(reset), .data_in(din_a), .valid_in(val_a),
      .ready_out(rdy_a), .data_out(dout_a), .word_start(ws_a),
      .is_data(isd_a), .data2send(d2s_a));

   parallel_serial_par #(.MSB_FIRST(1'b0)) u_lsb (
      .clk_4f(clk_4f), .reset(reset), .data_in(din_l), .valid_in(val_l),
      .ready_out(rdy_l), .data_out(dout_l), .word_start(ws_l),
      .is_data(isd_l), .data2send(d2s_l));

   parallel_serial_par #(.WIDTH(4), .LANES(2), .IDLE_WORD(4'hC)) u_dual (
      .clk_4f(clk_4f), .reset(reset), .data_in(din_d), .valid_in(val_d),
      .ready_out(rdy_d), .data_out(dout_d), .word_start(ws_d),
      .is_data(isd_d), .data2send(d2s_d));

   task automatic check(input string name, input int cyc,
                        input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   // Called right after a rising edge; returns on the release edge (cycle 0 next).
   task automatic do_reset();
      #1;
      reset = 1'b0;
      val_a = 1'b0; val_l = 1'b0; val_d = 1'b0;
      repeat (3) @(posedge clk_4f);
      #1;
      reset = 1'b1;
      @(posedge clk_4f);
   endtask

   task automatic apply_table(input int n);
      for (int c = 0; c < n; c++) begin
         #1;
         val_a = tbl[c].valid;
         din_a = tbl[c].din;
         @(negedge clk_4f);
         check("dout", c, 32'(dout_a), 32'(tbl[c].word[7 - (c % 8)]));
         check("word_start", c, 32'(ws_a), 32'((c % 8) == 0));
         check("is_data", c, 32'(isd_a), 32'(tbl[c].isd));
         check("ready", c, 32'(rdy_a), 32'(tbl[c].rdy));
         check("data2send", c, 32'(d2s_a), 32'(tbl[c].word));
         @(posedge clk_4f);
      end
   endtask

   initial begin
      logic [7:0] bc_v;
      bc_v  = 8'hBC;
      reset = 1'b0;
      val_a = 1'b0; val_l = 1'b0; val_d = 1'b0;
      din_a = 8'h00; din_l = 8'h00; din_d = 8'h00;

      // Reset state: every output low after an edge with reset asserted.
      repeat (2) @(posedge clk_4f);
      @(negedge clk_4f);
      check("rst_dout", 0, 32'(dout_a), 32'd0);
      check("rst_ws", 0, 32'(ws_a), 32'd0);
      check("rst_isd", 0, 32'(isd_a), 32'd0);
      check("rst_rdy", 0, 32'(rdy_a), 32'd0);
      check("rst_d2s", 0, 32'(d2s_a), 32'd0);
      @(posedge clk_4f);

      // Idle preamble and a single 8'hA5 accepted in cycle 10.
      for (int c = 0; c < 32; c++) begin
         tbl[c].valid = (c == 10);
         tbl[c].din   = (c == 10) ? 8'hA5 : 8'h00;
         tbl[c].isd   = (c >= 16 && c <= 23);
         tbl[c].word  = (c >= 16 && c <= 23) ? 8'hA5 : 8'hBC;
         tbl[c].rdy   = !((c < 8) || (c >= 11 && c <= 14));
      end
      do_reset();
      apply_table(32);

      // Back-to-back words with valid held; refused offers are ignored.
      for (int c = 0; c < 40; c++) begin
         tbl[c].valid = (c >= 8 && c <= 23);
         tbl[c].din   = (c <= 8) ? 8'h01 : (c <= 15) ? 8'h02 : 8'h03;
         tbl[c].isd   = (c >= 16);
         tbl[c].word  = (c < 16) ? 8'hBC : (c < 24) ? 8'h01 :
                        (c < 32) ? 8'h02 : 8'h03;
         tbl[c].rdy   = (c == 8) || (c == 15) || (c == 23) || (c >= 31);
      end
      do_reset();
      apply_table(40);

      // Reset in cycle 19 with 8'hA5 in flight and 8'h5A held.
      for (int c = 0; c < 19; c++) begin
         tbl[c].valid = (c == 8) || (c == 16);
         tbl[c].din   = (c == 16) ? 8'h5A : 8'hA5;
         tbl[c].isd   = (c >= 16);
         tbl[c].word  = (c >= 16) ? 8'hA5 : 8'hBC;
         tbl[c].rdy   = (c == 8) || (c == 15) || (c == 16);
      end
      do_reset();
      apply_table(19);
      #1;
      val_a = 1'b0;
      reset = 1'b0;
      @(posedge clk_4f);
      #1;
      reset = 1'b1;
      @(negedge clk_4f);
      check("abort_dout", 20, 32'(dout_a), 32'd0);
      check("abort_ws", 20, 32'(ws_a), 32'd0);
      check("abort_isd", 20, 32'(isd_a), 32'd0);
      check("abort_rdy", 20, 32'(rdy_a), 32'd0);
      check("abort_d2s", 20, 32'(d2s_a), 32'd0);
      @(posedge clk_4f);
      for (int c = 0; c < 24; c++) begin
         tbl[c].valid = 1'b0;
         tbl[c].din   = 8'h00;
         tbl[c].isd   = 1'b0;
         tbl[c].word  = 8'hBC;
         tbl[c].rdy   = (c >= 8);
      end
      apply_table(24);

      // LSB-first variant: idle comma then 8'h0F.
      do_reset();
      for (int c = 0; c < 24; c++) begin
         #1;
         val_l = (c == 8);
         din_l = 8'h0F;
         @(negedge clk_4f);
         if (c >= 8 && c < 16) begin
            check("lsb_idle", c, 32'(dout_l), 32'(bc_v[c - 8]));
         end else if (c >= 16) begin
            check("lsb_data", c, 32'(dout_l), 32'((c - 16) < 4));
            check("lsb_isd", c, 32'(isd_l), 32'd1);
         end else begin
            check("lsb_pre_isd", c, 32'(isd_l), 32'd0);
         end
         @(posedge clk_4f);
      end
      #1;
      val_l = 1'b0;

      // Two lanes of 4 bits: idle 4'hC on both, then lane0=C, lane1=3.
      do_reset();
      for (int c = 0; c < 12; c++) begin
         #1;
         val_d = (c == 4);
         din_d = 8'h3C;
         @(negedge clk_4f);
         if (c < 4) begin
            check("dual_idle", c, 32'(dout_d), (c < 2) ? 32'd3 : 32'd0);
            check("dual_idle_d2s", c, 32'(d2s_d), 32'hCC);
            check("dual_rdy_init", c, 32'(rdy_d), 32'd0);
         end else if (c >= 8) begin
            check("dual_data", c, 32'(dout_d), (c < 10) ? 32'd1 : 32'd2);
            check("dual_d2s", c, 32'(d2s_d), 32'h3C);
            check("dual_isd", c, 32'(isd_d), 32'd1);
         end else begin
            check("dual_ws", c, 32'(ws_d), 32'(c == 4));
         end
         @(posedge clk_4f);
      end
      #1;
      val_d = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
